uart_baud_gen: RTL and testbench
================================

// Module: uart_baud_gen
//
// PURPOSE
// Runtime-programmable UART baud generator with independent RX and TX timing channels.
// The RX channel emits oversample ticks, phase-aligned to mid-sample on rx_start. The TX channel emits one tick per bit period.
// The divisor is loaded through a valid/ready handshake, and an optional fractional part trims baud error.
// Sits between the CSR block and the uart_rx / uart_tx datapaths, replacing the fixed-divisor generator.
//
// PARAMETERS
// CLK_HZ        25000000  system clock frequency (Hz)
// DEFAULT_BAUD  9600      baud rate in effect after reset
// SAMPLE_RATE   16        oversample ticks per bit (>=2)
// DIV_W         16        width of the integer divisor
// FRAC_W        4         width of the fractional divisor (LSB = 1/2^FRAC_W)
//
// PORTS
// clock      in   1       system clock; all logic on posedge
// reset      in   1       asynchronous, active-high; clears all state
// cfg_valid  in   1       new divisor offered
// cfg_ready  out  1       divisor can be accepted (= ~rx_en & ~tx_en)
// cfg_int    in   DIV_W   integer divisor (clock cycles per oversample tick)
// cfg_frac   in   FRAC_W  fractional divisor
// rx_en      in   1       RX channel enable
// rx_start   in   1       start-bit edge seen; realign RX phase
// rx_tick    out  1       one-cycle oversample pulse
// tx_en      in   1       TX channel enable
// tx_start   in   1       frame start; restart TX bit timing
// tx_tick    out  1       one-cycle bit-period pulse
//
// BEHAVIOUR
// - Reset values: rx_tick=0, tx_tick=0, all counters and accumulators=0, div_int_q=DEFAULT_DIV, div_frac_q=0.
// - DEFAULT_DIV = CLK_HZ/(DEFAULT_BAUD*SAMPLE_RATE).
// - cfg_ready is combinational. A divisor loads on the edge where cfg_valid&cfg_ready; divisor values <2 are clamped to 2.
// - Ticks are registered pulses: a tick is high for exactly one cycle. At the minimum divisor of 2, ticks are never back-to-back.
// - The current period P is div_int_q, or div_int_q+1 when the extend flag is set.
// - Channel counter, on every edge:
//     - en=0: cnt<=0, acc<=0, extend<=0, tick<=0.
//     - Otherwise, on cnt==P-1: cnt<=0, tick<=1, acc<=acc+div_frac_q, extend<=carry-out of that add.
//     - Otherwise: cnt<=cnt+1, tick<=0.
// - RX: rx_start with rx_en=1 loads cnt<=div_int_q/2, acc<=0, extend<=0, tick<=0.
//     - The first rx_tick is high ceil(div/2) edges after the start edge; ticks then repeat every P cycles.
// - TX: the oversample counter feeds a bit counter 0..SAMPLE_RATE-1; tx_tick pulses when the bit counter wraps.
//     - tx_start clears the oversample counter, bit counter and acc.
//     - The first tx_tick is high SAMPLE_RATE*div edges after tx_start.
// - Simultaneous start and terminal count: start wins and no tick is issued that cycle.
//   The same rule applies to rx_start and tx_start.
// - rx_start / tx_start are ignored while the matching en=0.
// - Reset mid-frame aborts immediately; ticks drop asynchronously.
// - Counter widths are DIV_W bits, and acc has FRAC_W bits. The bit counter is $clog2(SAMPLE_RATE) bits. No overflow is possible given the clamp.
//
// CONFIGURATION
// FRAC_BAUD_EN defined:
//   - Fractional accumulators and the extend logic are present.
//   - The average period is cfg_int + cfg_frac/2^FRAC_W.
// FRAC_BAUD_EN undefined:
//   - cfg_frac is ignored and no accumulators are built; extend is tied to 0.
//   - The period is exactly div_int_q. Ports are unchanged.
//
// STRUCTURE
// - Package uart_pkg holds DIV_W, FRAC_W, the MIN_DIV=2 constant, and a baud_cfg_t struct {int, frac}.
// - Sub-module baud_div_channel holds one counter, accumulator, extend flag and tick register, with an align-load input.
//     - It is instantiated twice: RX loads div/2 on align, and TX loads 0.
//     - The TX instance is followed by the bit counter in the top level.
//
// TESTING
// 1. Reset, then rx_en=1 with no cfg: rx_tick period = 162 cycles (25 MHz / (9600*16)); tx_tick period = 2592.
// 2. cfg_int=4, frac=0, rx_start: first rx_tick 2 edges later, then every 4 cycles.
//    tx_start: first tx_tick at 64 edges.
// 3. FRAC_BAUD_EN, cfg_int=4, cfg_frac=8 (FRAC_W=4): rx_tick periods alternate 4,5,4,5.
//    Over 32 ticks, 144 cycles elapse.
// 4. cfg_valid with tx_en=1: cfg_ready=0 and the divisor is unchanged. Drop tx_en: the divisor loads on the next edge.
//    cfg_int=0 loaded: ticks every 2 cycles.
// 5. rx_start asserted on the same edge as a terminal count: no rx_tick, and the counter realigns to div/2.
// 6. Assert reset mid-frame: ticks go 0 without a clock edge. After release, the divisor is back to DEFAULT_DIV.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART baud generator.
//   DIV_W      default width of the integer divisor
//   FRAC_W     default width of the fractional divisor (LSB = 1/2^FRAC_W)
//   MIN_DIV    smallest divisor the generator will run at
//   baud_cfg_t divisor pair {int_div, frac} as offered by the CSR block
//   default_div() clock cycles per oversample tick for a given baud rate
package uart_pkg;

  localparam int DIV_W   = 16;
  localparam int FRAC_W  = 4;
  localparam int MIN_DIV = 2;

  typedef struct packed {
    logic [DIV_W-1:0]  int_div;
    logic [FRAC_W-1:0] frac;
  } baud_cfg_t;

  function automatic int default_div(input int clk_hz, input int baud, input int sample_rate);
    return clk_hz / (baud * sample_rate);
  endfunction

endpackage

// File: rtl/baud_div_channel.sv
// baud_div_channel: one baud timing channel (period counter, optional
// fractional accumulator with extend flag, registered tick).
// Optional feature macro: FRAC_BAUD_EN (fractional accumulator and extend).
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   en            channel enable; when low the channel is held cleared
//   align         realign: load cnt from align_cnt, clear acc/extend/tick
//   align_cnt     counter value loaded on align
//   div_int       integer period (already clamped to >= 2)
//   div_frac      fractional period increment
//   tick          one-cycle registered pulse at each period end
//   wrap          combinational: this edge is a terminal count (tick next)
module baud_div_channel
  import uart_pkg::*;
#(
  parameter int DIV_W  = uart_pkg::DIV_W,
  parameter int FRAC_W = uart_pkg::FRAC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              align,
  input  logic [DIV_W-1:0]  align_cnt,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick,
  output logic              wrap
);

  logic [DIV_W-1:0] cnt;
  logic             extend;
  logic             last;

  // Period is div_int, or div_int+1 when extended; compare against P-1
  // without forming P so div_int at full scale cannot overflow.
  assign last = extend ? (cnt == div_int) : (cnt == div_int - DIV_W'(1));
  // Align wins over a coincident terminal count.
  assign wrap = en & ~align & last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (align) begin
      cnt  <= align_cnt;
      tick <= 1'b0;
    end else if (last) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      tick <= 1'b0;
    end
  end

`ifdef FRAC_BAUD_EN
  logic [FRAC_W-1:0] acc;

  // The carry out of the fractional sum stretches the next period by one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      extend <= 1'b0;
    end else if (!en || align) begin
      acc    <= '0;
      extend <= 1'b0;
    end else if (last) begin
      {extend, acc} <= {1'b0, acc} + {1'b0, div_frac};
    end
  end
`else
  logic unused_div_frac;

  assign extend          = 1'b0;
  assign unused_div_frac = ^div_frac;
`endif

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: runtime-programmable UART baud generator with independent
// RX (oversample, mid-bit aligned) and TX (bit period) timing channels.
// Optional feature macro: FRAC_BAUD_EN (fractional divisor support; when
// undefined cfg_frac is ignored and periods are exactly the integer divisor).
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   cfg_valid     new divisor offered
//   cfg_ready     divisor can be accepted (both channels disabled)
//   cfg_int       integer divisor, clock cycles per oversample tick
//   cfg_frac      fractional divisor
//   rx_en         RX channel enable
//   rx_start      start-bit edge seen; realign RX phase to mid-sample
//   rx_tick       one-cycle oversample pulse
//   tx_en         TX channel enable
//   tx_start      frame start; restart TX bit timing
//   tx_tick       one-cycle bit-period pulse
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 25000000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int SAMPLE_RATE  = 16,
  parameter int DIV_W        = uart_pkg::DIV_W,
  parameter int FRAC_W       = uart_pkg::FRAC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic              rx_en,
  input  logic              rx_start,
  output logic              rx_tick,
  input  logic              tx_en,
  input  logic              tx_start,
  output logic              tx_tick
);

  localparam logic [DIV_W-1:0] DEFAULT_DIV =
    DIV_W'(default_div(CLK_HZ, DEFAULT_BAUD, SAMPLE_RATE));
  localparam int BIT_W = $clog2(SAMPLE_RATE);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
  endfunction

  logic [DIV_W-1:0]  div_int_q;
  logic [FRAC_W-1:0] div_frac_q;
  logic              tx_os_tick;
  logic              tx_wrap;
  logic              rx_wrap_unused;
  logic [BIT_W-1:0]  bit_cnt;

  // Divisor may only change while both channels are idle.
  assign cfg_ready = ~rx_en & ~tx_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_int_q <= DEFAULT_DIV;
    end else if (cfg_valid && cfg_ready) begin
      div_int_q <= clamp_div(cfg_int);
    end
  end

`ifdef FRAC_BAUD_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_frac_q <= '0;
    end else if (cfg_valid && cfg_ready) begin
      div_frac_q <= cfg_frac;
    end
  end
`else
  logic unused_cfg_frac;

  assign div_frac_q      = '0;
  assign unused_cfg_frac = ^cfg_frac;
`endif

  // RX realigns to half a period so later ticks land mid-sample.
  baud_div_channel #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .en        (rx_en),
    .align     (rx_start),
    .align_cnt (div_int_q >> 1),
    .div_int   (div_int_q),
    .div_frac  (div_frac_q),
    .tick      (rx_tick),
    .wrap      (rx_wrap_unused)
  );

  baud_div_channel #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_tx (
    .clock     (clock),
    .reset     (reset),
    .en        (tx_en),
    .align     (tx_start),
    .align_cnt ('0),
    .div_int   (div_int_q),
    .div_frac  (div_frac_q),
    .tick      (tx_os_tick),
    .wrap      (tx_wrap)
  );

  // Bit counter counts the registered oversample ticks, so it lags the
  // oversample terminal count by one edge. The TX tick is therefore taken
  // from the terminal count that ends the SAMPLE_RATE-th oversample period
  // while the counter already shows SAMPLE_RATE-1; the counter wraps on the
  // following edge when that period's oversample tick is counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      tx_tick <= 1'b0;
    end else if (!tx_en || tx_start) begin
      bit_cnt <= '0;
      tx_tick <= 1'b0;
    end else begin
      if (tx_os_tick) begin
        bit_cnt <= (bit_cnt == BIT_W'(SAMPLE_RATE - 1)) ? '0 : bit_cnt + BIT_W'(1);
      end
      tx_tick <= tx_wrap && (bit_cnt == BIT_W'(SAMPLE_RATE - 1));
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
module tb_uart_baud_gen;
  import uart_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [DIV_W-1:0]  cfg_int = '0;
  logic [FRAC_W-1:0] cfg_frac = '0;
  logic              rx_en = 1'b0;
  logic              rx_start = 1'b0;
  logic              rx_tick;
  logic              tx_en = 1'b0;
  logic              tx_start = 1'b0;
  logic              tx_tick;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rxq[$];
  int txq[$];
  int rx_e;
  int tx_e;

  uart_baud_gen dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_int   (cfg_int),
    .cfg_frac  (cfg_frac),
    .rx_en     (rx_en),
    .rx_start  (rx_start),
    .rx_tick   (rx_tick),
    .tx_en     (tx_en),
    .tx_start  (tx_start),
    .tx_tick   (tx_tick)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitors: each queue holds the edge numbers at which a tick
  // is required; ticks are sampled on the falling edge.
  always @(negedge clock) begin
    if (rx_tick) begin
      total++;
      if (rxq.size() == 0) begin
        bad++;
        $display("FAIL rx_tick_unexpected got_cycle=%0d want=none", cyc);
      end else begin
        rx_e = rxq.pop_front();
        if (rx_e != cyc) begin
          bad++;
          $display("FAIL rx_tick_time got_cycle=%0d want_cycle=%0d", cyc, rx_e);
        end
      end
    end else if (rxq.size() > 0 && rxq[0] < cyc) begin
      total++;
      bad++;
      rx_e = rxq.pop_front();
      $display("FAIL rx_tick_missed got_cycle=none want_cycle=%0d", rx_e);
    end
  end

  always @(negedge clock) begin
    if (tx_tick) begin
      total++;
      if (txq.size() == 0) begin
        bad++;
        $display("FAIL tx_tick_unexpected got_cycle=%0d want=none", cyc);
      end else begin
        tx_e = txq.pop_front();
        if (tx_e != cyc) begin
          bad++;
          $display("FAIL tx_tick_time got_cycle=%0d want_cycle=%0d", cyc, tx_e);
        end
      end
    end else if (txq.size() > 0 && txq[0] < cyc) begin
      total++;
      bad++;
      tx_e = txq.pop_front();
      $display("FAIL tx_tick_missed got_cycle=none want_cycle=%0d", tx_e);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic load_cfg(input baud_cfg_t c);
    @(negedge clock);
    cfg_valid = 1'b1;
    cfg_int   = c.int_div;
    cfg_frac  = c.frac;
    #1 check("cfg_ready_idle", int'(cfg_ready), 1);
    @(negedge clock);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int s;
    baud_cfg_t c;

    // Reset state
    #1;
    check("reset_rx_tick", int'(rx_tick), 0);
    check("reset_tx_tick", int'(tx_tick), 0);
    check("reset_cfg_ready", int'(cfg_ready), 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Default divisor 162: enable both channels without a start
    @(negedge clock);
    rx_en = 1'b1;
    tx_en = 1'b1;
    s = cyc + 1;
    #1 check("cfg_ready_busy", int'(cfg_ready), 0);
    for (int k = 0; k < 32; k++) rxq.push_back(s + 161 + 162 * k);
    txq.push_back(s + 2591);
    txq.push_back(s + 2591 + 2592);
    step_to(s + 5183);
    rx_en = 1'b0;
    tx_en = 1'b0;
    @(negedge clock);

    // Divisor 4: RX aligned to mid-sample, TX bit period 64
    c.int_div = 4; c.frac = 0;
    load_cfg(c);
    rx_en = 1'b1;
    rx_start = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 8; k++) rxq.push_back(s + 2 + 4 * k);
    @(negedge clock);
    rx_start = 1'b0;
    step_to(s + 30);
    rx_en = 1'b0;
    @(negedge clock);
    tx_en = 1'b1;
    tx_start = 1'b1;
    s = cyc + 1;
    txq.push_back(s + 64);
    txq.push_back(s + 128);
    @(negedge clock);
    tx_start = 1'b0;
    step_to(s + 128);
    tx_en = 1'b0;
    @(negedge clock);

`ifdef FRAC_BAUD_EN
    // Divisor 4.5: periods alternate 4,5; 32 periods take 144 cycles
    c.int_div = 4; c.frac = 8;
    load_cfg(c);
    rx_en = 1'b1;
    rx_start = 1'b1;
    s = cyc + 1;
    for (int k = 0; k <= 32; k++) rxq.push_back(s + 2 + 4 * k + k / 2);
    @(negedge clock);
    rx_start = 1'b0;
    step_to(s + 146);
    rx_en = 1'b0;
    @(negedge clock);
`endif

    // Config blocked while TX busy, then loads when TX drops; 0 clamps to 2
    c.int_div = 4; c.frac = 0;
    load_cfg(c);
    tx_en = 1'b1;
    tx_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_int = '0;
    cfg_frac = '0;
    s = cyc + 1;
    #1 check("cfg_ready_tx_busy", int'(cfg_ready), 0);
    txq.push_back(s + 64);
    @(negedge clock);
    tx_start = 1'b0;
    step_to(s + 64);
    tx_en = 1'b0;
    #1 check("cfg_ready_after_tx", int'(cfg_ready), 1);
    @(negedge clock);
    cfg_valid = 1'b0;
    rx_en = 1'b1;
    rx_start = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 6; k++) rxq.push_back(s + 1 + 2 * k);
    @(negedge clock);
    rx_start = 1'b0;
    step_to(s + 11);
    rx_en = 1'b0;
    @(negedge clock);

    // rx_start on a terminal count: start wins, no tick, realign to div/2
    c.int_div = 4; c.frac = 0;
    load_cfg(c);
    rx_en = 1'b1;
    rx_start = 1'b1;
    s = cyc + 1;
    rxq.push_back(s + 2);
    rxq.push_back(s + 6);
    @(negedge clock);
    rx_start = 1'b0;
    step_to(s + 9);
    rx_start = 1'b1;
    rxq.push_back(s + 12);
    rxq.push_back(s + 16);
    @(negedge clock);
    rx_start = 1'b0;
    step_to(s + 16);
    rx_en = 1'b0;
    @(negedge clock);

    // Reset mid-frame: tick drops with no clock edge; divisor back to default
    tx_en = 1'b1;
    tx_start = 1'b1;
    s = cyc + 1;
    txq.push_back(s + 64);
    @(negedge clock);
    tx_start = 1'b0;
    step_to(s + 64);
    #1 check("tx_tick_before_reset", int'(tx_tick), 1);
    reset = 1'b1;
    tx_en = 1'b0;
    #1 check("tx_tick_async_drop", int'(tx_tick), 0);
    check("rx_tick_in_reset", int'(rx_tick), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    rx_en = 1'b1;
    rx_start = 1'b1;
    s = cyc + 1;
    rxq.push_back(s + 81);
    rxq.push_back(s + 81 + 162);
    @(negedge clock);
    rx_start = 1'b0;
    step_to(s + 243);
    rx_en = 1'b0;
    repeat (4) @(negedge clock);

    check("rx_queue_drained", rxq.size(), 0);
    check("tx_queue_drained", txq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
